rf_alu_dm_datapath: RTL and testbench
=====================================

Name: rf_alu_dm_datapath

Overview:
- Core execute/memory datapath slice: a 32x32 register file, a 32-bit ALU and a 512-byte data memory, wired as one block.
- Each cycle it reads rs1/rs2 and computes in the ALU; a store goes to data memory and a register write-back happens at the clock edge.
- Sits under the CPU top level. The control unit drives the control inputs; debug ports feed the board display logic.

Parameters:
- DM_AW, 9, data-memory byte-address width (depth 2^DM_AW bytes).
- XLEN, 32, datapath width (fixed at 32; the parameter exists for documentation).

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- reg_write  in  1  register-file write enable
- rs1  in  5  read address A
- rs2  in  5  read address B
- rd  in  5  write address
- alu_src  in  1  0: ALU B = rd2; 1: ALU B = imm
- imm  in  32  immediate operand
- alu_op  in  5  ALU operation code
- mem_write  in  1  data-memory write enable
- dm_type  in  2  access size/sign
- mem_to_reg  in  1  0: write-back = alu_c; 1: write-back = dm_out
- rd1  out  32  register rs1 contents
- rd2  out  32  register rs2 contents
- alu_c  out  32  ALU result
- zero  out  1  alu_c == 0
- dm_out  out  32  load data
- dbg_raddr  in  5  debug register read address
- dbg_rdata  out  32  debug register contents
- dbg_maddr  in  DM_AW  debug memory byte address
- dbg_mdata  out  8  debug memory byte

Behaviour:
- Reset: if rst is high at a clock edge, all 32 registers and all DM bytes become 0, and writes in that cycle are suppressed. Outputs are combinational, so after reset they reflect zeros (alu_c depends on imm/op).
- RF reads:
  - rd1, rd2 and dbg_rdata are asynchronous reads.
  - x0 always reads 0 and writes to it are ignored.
  - Read-during-write returns the old value; there is no bypass.
- RF write: when reg_write=1 and rd≠0, regs[rd] <= (mem_to_reg ? dm_out : alu_c) at the rising edge.
- ALU: A = rd1, B = alu_src ? imm : rd2. Opcodes, combinational:
  - 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor
  - 00101 sll, 00110 srl, 00111 sra, using B[4:0] as the shift amount
  - 01000 slt (signed, 1/0), 01001 sltu, 01010 pass B
  - all other codes give C = 0
  - Add/sub wrap modulo 2^32. zero = (alu_c == 0).
- DM address is alu_c[DM_AW-1:0]. Memory is byte-organised and little-endian. Multi-byte accesses use bytes addr, addr+1, ... with wrap modulo 2^DM_AW. No alignment requirement.
- dm_type:
  - 00: word
  - 01: halfword, load sign-extended
  - 10: byte, load sign-extended
  - 11: byte, load zero-extended
  - Stores write the low 4/2/1 bytes of rd2.
- Store: when mem_write=1, bytes are written at the rising edge.
- Load: dm_out is an asynchronous read.
- A load in the same cycle as a store to the same bytes returns the old data.
- dbg_mdata is an asynchronous read of byte dbg_maddr.
- reg_write and mem_write may both be asserted in the same cycle; both take effect independently.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (ALU_ADD..ALU_PASSB)
  - DM type localparams (DM_WORD, DM_HALF, DM_BYTE, DM_BYTEU)
  - XLEN
- Three sub-modules are natural: dp_regfile, dp_alu, dp_dmem. The top level is wiring plus the B and write-back muxes.

Test Plan:
- Reset: assert rst for one cycle. Required: dbg_rdata = 0 for every register 0–31, and dbg_mdata = 0 at addresses 0, 255 and 511.
- Immediate add: rs1=0, alu_src=1, imm=5, alu_op=add, rd=1, reg_write=1. Then with rs1=1, imm=-3 → rd=2. Required: x1=5, x2=2. Then with rs1=1, rs2=2, alu_src=0, sub: alu_c=3, zero=0. With rs1=rs2=1, sub: zero=1.
- x0 protection: write rd=0 with imm=7 and reg_write=1. Required: dbg_rdata(0)=0 and rd1 at rs1=0 reads 0.
- Shifts and compares: A=x80000000 loaded via pass B, B=imm 4.
  - Required: sra gives F8000000, srl gives 08000000, sll gives 0.
  - slt(A,1)=1 and sltu(A,1)=0.
- Store/load sizes:
  - Required: storing x3=0x80FF1234 as a word at address 8 gives bytes 34,12,FF,80.
  - Half load at 10 gives FFFF80FF, byte load at 11 gives FFFFFF80, byteu load at 11 gives 00000080.
  - Byte store of 0xAB at 9 changes the word load at 8 to 80FFAB34.
- Wrap and write-back: word store of 0x11223344 at address 510. Required: bytes 510=44, 511=33, 0=22, 1=11. Then mem_to_reg=1 and a word load at 510 → rd=4 gives x4=11223344.

Source files
------------

// File: rtl/rf_alu_dm_datapath_pkg.sv
// Shared constants for the execute/memory datapath: ALU opcodes, data-memory
// access types and the datapath width.
package rf_alu_dm_datapath_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_SLT   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_PASSB = 5'b01010;

    localparam logic [1:0] DM_WORD  = 2'b00;
    localparam logic [1:0] DM_HALF  = 2'b01;
    localparam logic [1:0] DM_BYTE  = 2'b10;
    localparam logic [1:0] DM_BYTEU = 2'b11;

endpackage

// File: rtl/dp_alu.sv
// Combinational XLEN-bit ALU; shift amount comes from b[4:0], unknown
// opcodes produce zero.
module dp_alu
    import rf_alu_dm_datapath_pkg::*;
(
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] c
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        c = '0;
        case (op)
            ALU_ADD:   c = a + b;
            ALU_SUB:   c = a - b;
            ALU_AND:   c = a & b;
            ALU_OR:    c = a | b;
            ALU_XOR:   c = a ^ b;
            ALU_SLL:   c = a << shamt;
            ALU_SRL:   c = a >> shamt;
            ALU_SRA:   c = $signed(a) >>> shamt;
            ALU_SLT:   c = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  c = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASSB: c = b;
            default:   c = '0;
        endcase
    end

endmodule

// File: rtl/dp_dmem.sv
// Byte-organised little-endian data memory with async loads, synchronous
// stores, unaligned access and address wrap-around.
module dp_dmem
    import rf_alu_dm_datapath_pkg::*;
#(
    parameter int DM_AW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       dm_type,
    input  logic [DM_AW-1:0] addr,
    input  logic [XLEN-1:0]  wd,
    input  logic [DM_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]  rdata,
    output logic [7:0]       dbg_data
);

    localparam int DEPTH = 1 << DM_AW;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [DM_AW-1:0] byte_addr [4];
    logic [7:0]       rbyte [4];

    // Successive byte addresses wrap naturally in DM_AW bits.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr + DM_AW'(k);
            rbyte[k]     = mem_q[byte_addr[k]];
        end
    end

    always_comb begin
        case (dm_type)
            DM_WORD: rdata = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
            DM_HALF: rdata = {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
            DM_BYTE: rdata = {{24{rbyte[0][7]}}, rbyte[0]};
            default: rdata = {24'b0, rbyte[0]};
        endcase
    end

    assign dbg_data = mem_q[dbg_addr];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[byte_addr[0]] = wd[7:0];
            if ((dm_type == DM_WORD) || (dm_type == DM_HALF)) begin
                mem_d[byte_addr[1]] = wd[15:8];
            end
            if (dm_type == DM_WORD) begin
                mem_d[byte_addr[2]] = wd[23:16];
                mem_d[byte_addr[3]] = wd[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/dp_regfile.sv
// 32 x XLEN register file: two async read ports plus a debug port, one
// synchronous write port; x0 is hard-wired to zero.
module dp_regfile
    import rf_alu_dm_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      dbg_ra,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] dbg_rd
);

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];

    // Reads see the pre-edge contents; there is no write-to-read bypass.
    assign rd1    = regs_q[ra1];
    assign rd2    = regs_q[ra2];
    assign dbg_rd = regs_q[dbg_ra];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/rf_alu_dm_datapath.sv
// Execute/memory datapath slice: register file, ALU and data memory plus the
// ALU-B and write-back multiplexers.
module rf_alu_dm_datapath #(
    parameter int DM_AW = 9,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             alu_src,
    input  logic [XLEN-1:0]  imm,
    input  logic [4:0]       alu_op,
    input  logic             mem_write,
    input  logic [1:0]       dm_type,
    input  logic             mem_to_reg,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2,
    output logic [XLEN-1:0]  alu_c,
    output logic             zero,
    output logic [XLEN-1:0]  dm_out,
    input  logic [4:0]       dbg_raddr,
    output logic [XLEN-1:0]  dbg_rdata,
    input  logic [DM_AW-1:0] dbg_maddr,
    output logic [7:0]       dbg_mdata
);

    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] wb_data;

    assign alu_b   = alu_src ? imm : rd2;
    assign wb_data = mem_to_reg ? dm_out : alu_c;
    assign zero    = (alu_c == '0);

    dp_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (reg_write),
        .ra1    (rs1),
        .ra2    (rs2),
        .wa     (rd),
        .wd     (wb_data),
        .dbg_ra (dbg_raddr),
        .rd1    (rd1),
        .rd2    (rd2),
        .dbg_rd (dbg_rdata)
    );

    dp_alu u_alu (
        .op (alu_op),
        .a  (rd1),
        .b  (alu_b),
        .c  (alu_c)
    );

    dp_dmem #(
        .DM_AW (DM_AW)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .we       (mem_write),
        .dm_type  (dm_type),
        .addr     (alu_c[DM_AW-1:0]),
        .wd       (rd2),
        .dbg_addr (dbg_maddr),
        .rdata    (dm_out),
        .dbg_data (dbg_mdata)
    );

endmodule

// File: tb/tb_rf_alu_dm_datapath.sv
// Bench for rf_alu_dm_datapath: directed literal checks followed by random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_rf_alu_dm_datapath;
    import rf_alu_dm_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alu_src;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        mem_write;
    logic [1:0]  dm_type;
    logic        mem_to_reg;
    logic [31:0] rd1_w;
    logic [31:0] rd2_w;
    logic [31:0] alu_c_w;
    logic        zero_w;
    logic [31:0] dm_out_w;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata_w;
    logic [8:0]  dbg_maddr;
    logic [7:0]  dbg_mdata_w;

    int total_cnt = 0;
    int bad_cnt   = 0;
    bit check_en  = 1'b0;

    logic [31:0] m_regs [32];
    logic [7:0]  m_mem [512];

    always #5 clk = ~clk;

    rf_alu_dm_datapath #(
        .DM_AW (9),
        .XLEN  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .alu_src    (alu_src),
        .imm        (imm),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .dm_type    (dm_type),
        .mem_to_reg (mem_to_reg),
        .rd1        (rd1_w),
        .rd2        (rd2_w),
        .alu_c      (alu_c_w),
        .zero       (zero_w),
        .dm_out     (dm_out_w),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata_w),
        .dbg_maddr  (dbg_maddr),
        .dbg_mdata  (dbg_mdata_w)
    );

    function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << sh;
            5'd6:  return a >> sh;
            5'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            5'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_size(input logic [1:0] t);
        return (t == 2'd0) ? 4 : ((t == 2'd1) ? 2 : 1);
    endfunction

    function automatic logic [31:0] m_load(input int base, input logic [1:0] t);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < m_size(t); k++) begin
            v = v | (32'(m_mem[(base + k) % 512]) << (8 * k));
        end
        if (t == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        if (t == 2'd2 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic logic [31:0] m_alu_now();
        logic [31:0] b;
        b = alu_src ? imm : m_regs[rs2];
        return m_alu(alu_op, m_regs[rs1], b);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        logic [31:0] c;
        c = m_alu_now();
        checkOutput("rd1", rd1_w, m_regs[rs1]);
        checkOutput("rd2", rd2_w, m_regs[rs2]);
        checkOutput("alu_c", alu_c_w, c);
        checkOutput("zero", {31'b0, zero_w}, {31'b0, c == 32'd0});
        checkOutput("dm_out", dm_out_w, m_load(int'(c[8:0]), dm_type));
        checkOutput("dbg_rdata", dbg_rdata_w, m_regs[dbg_raddr]);
        checkOutput("dbg_mdata", {24'b0, dbg_mdata_w}, {24'b0, m_mem[dbg_maddr]});
    endtask

    task automatic modelCommit();
        logic [31:0] c;
        logic [31:0] wb;
        logic [31:0] src;
        int base;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            for (int i = 0; i < 512; i++) m_mem[i] = 8'd0;
            return;
        end
        c    = m_alu_now();
        base = int'(c[8:0]);
        wb   = mem_to_reg ? m_load(base, dm_type) : c;
        src  = m_regs[rs2];
        if (mem_write) begin
            for (int k = 0; k < m_size(dm_type); k++) begin
                m_mem[(base + k) % 512] = 8'(src >> (8 * k));
            end
        end
        if (reg_write && rd != 5'd0) m_regs[rd] = wb;
    endtask

    task automatic applyStimulus(input logic rw, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rdv, input logic asrc, input logic [31:0] immv,
                                 input logic [4:0] op, input logic mw, input logic [1:0] dt,
                                 input logic m2r);
        reg_write  = rw;
        rs1        = r1;
        rs2        = r2;
        rd         = rdv;
        alu_src    = asrc;
        imm        = immv;
        alu_op     = op;
        mem_write  = mw;
        dm_type    = dt;
        mem_to_reg = m2r;
    endtask

    task automatic sample();
        @(negedge clk);
        if (check_en) compareModel();
    endtask

    task automatic commitCycle();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd0, ALU_ADD, 1'b0, DM_WORD, 1'b0);
    endtask

    task automatic loadReg(input logic [4:0] r, input logic [31:0] v);
        applyStimulus(1'b1, 5'd0, 5'd0, r, 1'b1, v, ALU_PASSB, 1'b0, DM_WORD, 1'b0);
        sample();
        commitCycle();
    endtask

    task automatic peekByte(input string name, input logic [8:0] a, input logic [7:0] exp);
        idle();
        dbg_maddr = a;
        sample();
        checkOutput(name, {24'b0, dbg_mdata_w}, {24'b0, exp});
        commitCycle();
    endtask

    task automatic loadCheck(input string name, input logic [31:0] a, input logic [1:0] dt,
                             input logic [31:0] exp);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, a, ALU_ADD, 1'b0, dt, 1'b0);
        sample();
        checkOutput(name, dm_out_w, exp);
        commitCycle();
    endtask

    logic [4:0]  sh_ops [5] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLT, ALU_SLTU};
    logic [31:0] sh_imm [5] = '{32'd4, 32'd4, 32'd4, 32'd1, 32'd1};
    logic [31:0] sh_exp [5] = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'd1, 32'd0};

    initial begin
        rst       = 1'b1;
        dbg_raddr = 5'd0;
        dbg_maddr = 9'd0;
        idle();
        commitCycle();
        rst      = 1'b0;
        check_en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            idle();
            dbg_raddr = 5'(i);
            sample();
            checkOutput("reset_reg", dbg_rdata_w, 32'd0);
            commitCycle();
        end
        peekByte("reset_mem0", 9'd0, 8'h00);
        peekByte("reset_mem255", 9'd255, 8'h00);
        peekByte("reset_mem511", 9'd511, 8'h00);

        applyStimulus(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, ALU_ADD, 1'b0, DM_WORD, 1'b0);
        sample();
        checkOutput("addi_x1", alu_c_w, 32'd5);
        commitCycle();
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 32'hFFFF_FFFD, ALU_ADD, 1'b0, DM_WORD, 1'b0);
        sample();
        checkOutput("addi_x2", alu_c_w, 32'd2);
        commitCycle();

        applyStimulus(1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'd0, ALU_SUB, 1'b0, DM_WORD, 1'b0);
        dbg_raddr = 5'd1;
        sample();
        checkOutput("x1_val", dbg_rdata_w, 32'd5);
        checkOutput("x2_val", rd2_w, 32'd2);
        checkOutput("sub_c", alu_c_w, 32'd3);
        checkOutput("sub_zero0", {31'b0, zero_w}, 32'd0);
        commitCycle();
        applyStimulus(1'b0, 5'd1, 5'd1, 5'd0, 1'b0, 32'd0, ALU_SUB, 1'b0, DM_WORD, 1'b0);
        sample();
        checkOutput("sub_zero1", {31'b0, zero_w}, 32'd1);
        commitCycle();

        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7, ALU_ADD, 1'b0, DM_WORD, 1'b0);
        sample();
        commitCycle();
        idle();
        dbg_raddr = 5'd0;
        sample();
        checkOutput("x0_dbg", dbg_rdata_w, 32'd0);
        checkOutput("x0_rd1", rd1_w, 32'd0);
        commitCycle();

        loadReg(5'd3, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 5'd3, 5'd0, 5'd0, 1'b1, sh_imm[i], sh_ops[i], 1'b0, DM_WORD, 1'b0);
            sample();
            checkOutput("shift_cmp", alu_c_w, sh_exp[i]);
            commitCycle();
        end

        loadReg(5'd3, 32'h80FF_1234);
        applyStimulus(1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 32'd8, ALU_ADD, 1'b1, DM_WORD, 1'b0);
        sample();
        commitCycle();
        peekByte("sw_b8", 9'd8, 8'h34);
        peekByte("sw_b9", 9'd9, 8'h12);
        peekByte("sw_b10", 9'd10, 8'hFF);
        peekByte("sw_b11", 9'd11, 8'h80);
        loadCheck("lh_10", 32'd10, DM_HALF, 32'hFFFF_80FF);
        loadCheck("lb_11", 32'd11, DM_BYTE, 32'hFFFF_FF80);
        loadCheck("lbu_11", 32'd11, DM_BYTEU, 32'h0000_0080);

        loadReg(5'd5, 32'h0000_00AB);
        applyStimulus(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'd9, ALU_ADD, 1'b1, DM_BYTE, 1'b0);
        sample();
        commitCycle();
        loadCheck("lw_8_after_sb", 32'd8, DM_WORD, 32'h80FF_AB34);

        loadReg(5'd6, 32'h1122_3344);
        applyStimulus(1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 32'd510, ALU_ADD, 1'b1, DM_WORD, 1'b0);
        sample();
        commitCycle();
        peekByte("wrap_b510", 9'd510, 8'h44);
        peekByte("wrap_b511", 9'd511, 8'h33);
        peekByte("wrap_b0", 9'd0, 8'h22);
        peekByte("wrap_b1", 9'd1, 8'h11);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'd510, ALU_ADD, 1'b0, DM_WORD, 1'b1);
        sample();
        checkOutput("lw_wrap", dm_out_w, 32'h1122_3344);
        commitCycle();
        idle();
        dbg_raddr = 5'd4;
        sample();
        checkOutput("x4_wb", dbg_rdata_w, 32'h1122_3344);
        commitCycle();

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          1'($urandom),
                          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 600)) : $urandom,
                          5'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                          2'($urandom), 1'($urandom));
            dbg_raddr = 5'($urandom);
            dbg_maddr = 9'($urandom);
            sample();
            commitCycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
